// File: rtl/vga_frame_streamer.sv
// Avalon-MM burst read master that streams a framebuffer from SDRAM into the VGA
// clock-crossing FIFO, with space-checked bursts, double buffering and error flags.
module vga_frame_streamer #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 32,
    parameter int                USED_W     = 9,
    parameter int                FIFO_DEPTH = 512,
    parameter int                BURST_LEN  = 8,
    parameter int                H_RES      = 640,
    parameter int                V_RES      = 480,
    parameter logic [ADDR_W-1:0] FB0_BASE   = '0,
    parameter logic [ADDR_W-1:0] FB1_BASE   = ADDR_W'(32'h96000),
    localparam int               BC_W       = $clog2(BURST_LEN) + 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              enable,
    input  logic              pll_locked,
    input  logic              buf_sel,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [BC_W-1:0]   avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              fifo_full,
    input  logic [USED_W-1:0] fifo_used,
    input  logic              fifo_empty,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_data,
    output logic              cur_buf,
    output logic              frame_start,
    output logic              frame_done,
    output logic              overflow_err,
    output logic              underrun_err
);

    localparam int TOTAL = H_RES * V_RES;
    localparam int REM_W = $clog2(TOTAL + 1);
    localparam int BYTES = DATA_W / 8;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_RECV, S_SETTLE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [REM_W-1:0]  r_remain;
    logic [BC_W-1:0]   r_beats;
    logic [BC_W-1:0]   r_beat_cnt;
    logic              r_armed;

    logic [BC_W-1:0]   w_beats;
    logic [31:0]       w_space;
    logic              w_go;
    logic [ADDR_W-1:0] w_base;

    // A burst is only issued when the whole of it is guaranteed to fit in the FIFO.
    always_comb begin
        w_beats = (32'(r_remain) >= 32'(BURST_LEN)) ? BC_W'(BURST_LEN) : BC_W'(r_remain);
        w_space = 32'(FIFO_DEPTH) - 32'(fifo_used);
        w_go    = (w_space >= 32'(w_beats)) && !fifo_full;
        w_base  = buf_sel ? FB1_BASE : FB0_BASE;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_remain       <= '0;
            r_beats        <= '0;
            r_beat_cnt     <= '0;
            r_armed        <= 1'b0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_burstcount <= '0;
            fifo_wr_en     <= 1'b0;
            fifo_data      <= '0;
            cur_buf        <= 1'b0;
            frame_start    <= 1'b0;
            frame_done     <= 1'b0;
            overflow_err   <= 1'b0;
            underrun_err   <= 1'b0;
        end else begin
            fifo_wr_en  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;

            if (fifo_wr_en && fifo_full)
                overflow_err <= 1'b1;
            if (r_armed && fifo_empty && r_state != S_IDLE)
                underrun_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (enable && pll_locked) begin
                        cur_buf  <= buf_sel;
                        r_addr   <= w_base;
                        r_remain <= REM_W'(TOTAL);
                        r_state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!enable || !pll_locked) begin
                        r_state <= S_IDLE;
                    end else if (w_go) begin
                        avm_read       <= 1'b1;
                        avm_address    <= r_addr;
                        avm_burstcount <= w_beats;
                        r_beats        <= w_beats;
                        frame_start    <= (r_remain == REM_W'(TOTAL));
                        r_state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read   <= 1'b0;
                        r_beat_cnt <= '0;
                        r_state    <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (avm_readdatavalid) begin
                        fifo_data  <= avm_readdata;
                        fifo_wr_en <= 1'b1;
                        r_beat_cnt <= r_beat_cnt + BC_W'(1);
                        if (r_beat_cnt == r_beats - BC_W'(1)) begin
                            r_addr   <= r_addr + ADDR_W'(r_beats) * ADDR_W'(BYTES);
                            r_remain <= r_remain - REM_W'(r_beats);
                            r_state  <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    // Buffer swap is only taken at a frame boundary.
                    if (r_remain == '0) begin
                        frame_done <= 1'b1;
                        r_armed    <= 1'b1;
                        r_addr     <= w_base;
                        r_remain   <= REM_W'(TOTAL);
                        cur_buf    <= buf_sel;
                    end
                    r_state <= S_CHECK;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_streamer.sv
// Directed bench for vga_frame_streamer: a small 10x1 frame with an Avalon burst slave model
// and a FIFO write monitor; each task checks one behaviour.
module tb_vga_frame_streamer;

    localparam logic [31:0] FB0 = 32'h100;
    localparam logic [31:0] FB1 = 32'h2000;

    logic        clk_clk = 1'b0;
    logic        reset_reset, enable, pll_locked, buf_sel;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic [15:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        fifo_full, fifo_empty;
    logic [8:0]  fifo_used;
    logic        fifo_wr_en;
    logic [15:0] fifo_data;
    logic        cur_buf, frame_start, frame_done, overflow_err, underrun_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] req_addr_q[$];
    int          req_bc_q[$];
    logic [15:0] wr_q[$];
    int          fd_cnt = 0;
    int          fd_wr_at = 0;
    int          fs_cnt = 0;

    vga_frame_streamer #(
        .DATA_W(16), .ADDR_W(32), .USED_W(9), .FIFO_DEPTH(512), .BURST_LEN(8),
        .H_RES(10), .V_RES(1), .FB0_BASE(FB0), .FB1_BASE(FB1)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable), .pll_locked(pll_locked),
        .buf_sel(buf_sel), .avm_address(avm_address), .avm_read(avm_read),
        .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .fifo_full(fifo_full), .fifo_used(fifo_used), .fifo_empty(fifo_empty),
        .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .cur_buf(cur_buf),
        .frame_start(frame_start), .frame_done(frame_done),
        .overflow_err(overflow_err), .underrun_err(underrun_err)
    );

    always #5 clk_clk = ~clk_clk;

    function automatic logic [15:0] pix(input logic [31:0] a);
        return a[15:0] ^ 16'hC3C3;
    endfunction

    // Slave: accepts a burst when read && !waitrequest, returns beats back to back one cycle later.
    initial begin : slave
        logic [31:0] a;
        int          bc;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clk_clk); #2;
            if (avm_read && !avm_waitrequest && !reset_reset) begin
                a  = avm_address;
                bc = int'(avm_burstcount);
                req_addr_q.push_back(a);
                req_bc_q.push_back(bc);
                @(negedge clk_clk); #2;
                for (int i = 0; i < bc; i++) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = pix(a + 32'(2 * i));
                    @(negedge clk_clk); #2;
                end
                avm_readdatavalid = 1'b0;
            end
        end
    end

    always @(negedge clk_clk) begin
        if (fifo_wr_en) wr_q.push_back(fifo_data);
        if (frame_done) begin
            fd_cnt   = fd_cnt + 1;
            fd_wr_at = wr_q.size();
        end
        if (frame_start) fs_cnt = fs_cnt + 1;
    end

    task automatic tick();
        @(negedge clk_clk); #1;
    endtask

    task automatic do_reset();
        enable = 1'b0; avm_waitrequest = 1'b0; fifo_full = 1'b0; fifo_used = '0;
        fifo_empty = 1'b0; buf_sel = 1'b0; pll_locked = 1'b1;
        repeat (20) tick();
        reset_reset = 1'b1;
        repeat (3) tick();
        reset_reset = 1'b0;
        tick();
    endtask

    task automatic wait_reqs(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (req_addr_q.size() >= n) ok = 1;
            else tick();
        end
    endtask

    task automatic wait_writes(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (wr_q.size() >= n) ok = 1;
            else tick();
        end
    endtask

    task automatic wait_frame_done(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (fd_cnt >= n) ok = 1;
            else tick();
        end
    endtask

    task automatic test_reset();
        reset_reset = 1'b1; enable = 1'b1;
        tick(); tick();
        checks++;
        if ({avm_read, fifo_wr_en, frame_start, frame_done, cur_buf, overflow_err, underrun_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000000",
                     {avm_read, fifo_wr_en, frame_start, frame_done, cur_buf, overflow_err, underrun_err});
        end
        checks++;
        if (avm_burstcount !== 4'd0) begin
            failures++; $display("FAIL reset_burstcount got=%0d exp=0", avm_burstcount);
        end
        checks++;
        if (avm_address !== 32'd0 || fifo_data !== 16'd0) begin
            failures++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", avm_address, fifo_data);
        end
        reset_reset = 1'b0; enable = 1'b0;
        tick();
    endtask

    task automatic test_first_burst();
        int r0, w0; bit ok;
        do_reset();
        r0 = req_addr_q.size(); w0 = wr_q.size();
        enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (avm_read) ok = 1;
        end
        checks++;
        if (!ok) begin
            failures++; $display("FAIL first_req_timeout got=no_read exp=read");
        end else begin
            checks++;
            if (frame_start !== 1'b1) begin
                failures++; $display("FAIL first_frame_start got=%b exp=1", frame_start);
            end
            checks++;
            if (avm_address !== FB0 || avm_burstcount !== 4'd8) begin
                failures++; $display("FAIL first_req got=%h/%0d exp=%h/8", avm_address, avm_burstcount, FB0);
            end
        end
        wait_writes(w0 + 8, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL first_writes_timeout got=%0d exp=8", wr_q.size() - w0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wr_q[w0 + i] !== pix(FB0 + 32'(2 * i))) begin
                    failures++;
                    $display("FAIL first_data[%0d] got=%h exp=%h", i, wr_q[w0 + i], pix(FB0 + 32'(2 * i)));
                end
            end
        end
        wait_reqs(r0 + 2, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL second_req_timeout got=%0d exp=2", req_addr_q.size() - r0);
        end else begin
            checks++;
            if (req_addr_q[r0 + 1] !== FB0 + 32'd16 || req_bc_q[r0 + 1] != 2) begin
                failures++;
                $display("FAIL second_req got=%h/%0d exp=%h/2", req_addr_q[r0 + 1], req_bc_q[r0 + 1], FB0 + 32'd16);
            end
        end
    endtask

    task automatic test_short_final();
        int r0, w0, f0, s0; bit ok;
        do_reset();
        r0 = req_addr_q.size(); w0 = wr_q.size(); f0 = fd_cnt; s0 = fs_cnt;
        enable = 1'b1;
        wait_frame_done(f0 + 1, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL frame_done_timeout got=none exp=pulse");
        end else begin
            checks++;
            if (fd_wr_at - w0 != 10) begin
                failures++; $display("FAIL frame_done_at got=%0d exp=10", fd_wr_at - w0);
            end
            checks++;
            if (wr_q[w0 + 8] !== pix(FB0 + 32'd16) || wr_q[w0 + 9] !== pix(FB0 + 32'd18)) begin
                failures++;
                $display("FAIL short_data got=%h,%h exp=%h,%h", wr_q[w0 + 8], wr_q[w0 + 9],
                         pix(FB0 + 32'd16), pix(FB0 + 32'd18));
            end
        end
        wait_reqs(r0 + 3, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL frame2_req_timeout got=%0d exp=3", req_addr_q.size() - r0);
        end else begin
            checks++;
            if (req_addr_q[r0 + 2] !== FB0 || req_bc_q[r0 + 2] != 8) begin
                failures++;
                $display("FAIL frame2_req got=%h/%0d exp=%h/8", req_addr_q[r0 + 2], req_bc_q[r0 + 2], FB0);
            end
            checks++;
            if (fs_cnt - s0 != 2) begin
                failures++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt - s0);
            end
        end
    endtask

    task automatic test_space();
        bit seen;
        do_reset();
        fifo_full = 1'b1; enable = 1'b1;
        seen = 0;
        repeat (8) begin tick(); if (avm_read) seen = 1; end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL full_hold got=read exp=no_read");
        end
        fifo_full = 1'b0; fifo_used = 9'd505;
        seen = 0;
        repeat (12) begin tick(); if (avm_read) seen = 1; end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL space7_hold got=read exp=no_read");
        end
        fifo_used = 9'd504;
        tick();
        checks++;
        if (avm_read !== 1'b1 || avm_burstcount !== 4'd8) begin
            failures++; $display("FAIL space8_req got=%b/%0d exp=1/8", avm_read, avm_burstcount);
        end
    endtask

    task automatic test_waitrequest();
        int w0; bit ok;
        do_reset();
        w0 = wr_q.size();
        avm_waitrequest = 1'b1; enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (avm_read) ok = 1;
        end
        checks++;
        if (!ok) begin
            failures++; $display("FAIL wait_req_timeout got=no_read exp=read");
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (avm_read !== 1'b1 || avm_address !== FB0 || avm_burstcount !== 4'd8) begin
                failures++;
                $display("FAIL wait_stable[%0d] got=%b/%h/%0d exp=1/%h/8", c, avm_read, avm_address, avm_burstcount, FB0);
            end
            tick();
        end
        avm_waitrequest = 1'b0;
        tick();
        checks++;
        if (avm_read !== 1'b0) begin
            failures++; $display("FAIL wait_release got=%b exp=0", avm_read);
        end
        wait_writes(w0 + 8, ok);
        checks++;
        if (!ok || wr_q[w0] !== pix(FB0) || wr_q[w0 + 7] !== pix(FB0 + 32'd14)) begin
            failures++; $display("FAIL wait_data got=%0d_writes exp=8_in_order", wr_q.size() - w0);
        end
    endtask

    task automatic test_buf_swap();
        int r0, f0, n; bit ok, bad, done;
        do_reset();
        r0 = req_addr_q.size(); f0 = fd_cnt;
        enable = 1'b1;
        wait_reqs(r0 + 1, ok);
        buf_sel = 1'b1;
        bad = 0; done = 0; n = 0;
        while (!done && n < 300) begin
            tick(); n++;
            if (fd_cnt > f0) done = 1;
            else if (cur_buf !== 1'b0) bad = 1;
        end
        checks++;
        if (!done || bad) begin
            failures++; $display("FAIL swap_hold got=done%b_early%b exp=done1_early0", done, bad);
        end
        checks++;
        if (cur_buf !== 1'b1) begin
            failures++; $display("FAIL swap_cur_buf got=%b exp=1", cur_buf);
        end
        wait_reqs(r0 + 3, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL swap_req_timeout got=%0d exp=3", req_addr_q.size() - r0);
        end else begin
            checks++;
            if (req_addr_q[r0 + 1] !== FB0 + 32'd16 || req_addr_q[r0 + 2] !== FB1) begin
                failures++;
                $display("FAIL swap_addr got=%h,%h exp=%h,%h", req_addr_q[r0 + 1], req_addr_q[r0 + 2], FB0 + 32'd16, FB1);
            end
        end
    endtask

    task automatic test_errors();
        int r0, w0, f0; bit ok;
        do_reset();
        r0 = req_addr_q.size(); w0 = wr_q.size(); f0 = fd_cnt;
        fifo_empty = 1'b1; enable = 1'b1;
        wait_reqs(r0 + 1, ok);
        fifo_full = 1'b1;
        wait_writes(w0 + 1, ok);
        checks++;
        if (!ok || overflow_err !== 1'b0) begin
            failures++; $display("FAIL ovf_before got=%b exp=0", overflow_err);
        end
        tick();
        checks++;
        if (overflow_err !== 1'b1) begin
            failures++; $display("FAIL ovf_set got=%b exp=1", overflow_err);
        end
        fifo_full = 1'b0;
        checks++;
        if (underrun_err !== 1'b0) begin
            failures++; $display("FAIL unr_unarmed got=%b exp=0", underrun_err);
        end
        wait_frame_done(f0 + 1, ok);
        checks++;
        if (!ok || underrun_err !== 1'b0) begin
            failures++; $display("FAIL unr_at_done got=%b exp=0", underrun_err);
        end
        tick(); tick();
        checks++;
        if (underrun_err !== 1'b1) begin
            failures++; $display("FAIL unr_set got=%b exp=1", underrun_err);
        end
        enable = 1'b0; fifo_empty = 1'b0;
        repeat (20) tick();
        checks++;
        if (overflow_err !== 1'b1 || underrun_err !== 1'b1) begin
            failures++; $display("FAIL err_sticky got=%b%b exp=11", overflow_err, underrun_err);
        end
        reset_reset = 1'b1;
        tick(); tick();
        reset_reset = 1'b0;
        checks++;
        if (overflow_err !== 1'b0 || underrun_err !== 1'b0) begin
            failures++; $display("FAIL err_clear got=%b%b exp=00", overflow_err, underrun_err);
        end
    endtask

    initial begin
        reset_reset = 1'b1; enable = 1'b0; pll_locked = 1'b1; buf_sel = 1'b0;
        avm_waitrequest = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b0; fifo_used = '0;
        do_reset();
        test_reset();
        test_first_burst();
        test_short_final();
        test_space();
        test_waitrequest();
        test_buf_swap();
        test_errors();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
